// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel coordinates from a VGA-style stream (active-low hsync/vsync
// plus 3-3-2 RGB). It qualifies everything on i_pix_stb. It locks onto the
// line timing first and then onto the frame timing. Once locked it emits the
// visible pixels with their x/y position.
//
// Pipeline: each strobe registers hs/vs/RGB. On the next strobe that sample is
// edge-checked and counted, and the result is loaded into the outputs. The
// outputs therefore describe the sample taken one strobe earlier.
//
// Optional feature: define VGA_DEC_ERRCNT_EN to build the saturating 8-bit
// error counter behind o_err_cnt. Without it, o_err_cnt is tied to zero.
//
// Ports
//   i_clk          system clock (single domain)
//   i_rst          synchronous active-high reset
//   i_pix_stb      pixel strobe; all sampling and counting happen on it only
//   i_hs, i_vs     active-low horizontal / vertical sync
//   i_red/green/blue  3/3/2-bit colour
//   o_x, o_y       decoded column / row of the visible pixel (0 when o_de=0)
//   o_de           visible pixel valid
//   o_pixel        {red,green,blue} of the decoded pixel (0 when o_de=0)
//   o_locked       line and frame timing both locked
//   o_frame_start  pulses with the pixel at x=0, y=0
//   o_err          one-strobe pulse on a timing violation while locking/locked
//   o_err_cnt      saturating count of o_err pulses (optional, else 0)
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic [2:0] i_red,
  input  logic [2:0] i_green,
  input  logic [1:0] i_blue,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_de,
  output logic [7:0] o_pixel,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic       o_err,
  output logic [7:0] o_err_cnt
);

  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_OVER   = 10'(H_TOTAL);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_HLOCK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e     state_q, state_d;

  // Input sample and the sample before it, for falling-edge detection.
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [7:0] rgb_q;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vpend_q, vpend_d;   // vsync seen, waiting for next hsync edge

  logic       hs_edge, vs_edge, v_reset;
  logic       h_bad, v_bad, err_d;

  logic       h_act, v_act, de_d, fs_d;
  logic [9:0] x_d;
  logic [8:0] y_d;
  logic [7:0] pixel_d;

  logic       de_q, fs_q, err_q;
  logic [9:0] x_q;
  logic [8:0] y_q;
  logic [7:0] pixel_q;

  assign hs_edge = hs_prev_q & ~hs_q;
  assign vs_edge = vs_prev_q & ~vs_q;

  // Counter next-state, meaningful only on a strobe.
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    vpend_d = vpend_q;
    v_reset = 1'b0;

    if (hs_edge) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    if (hs_edge) begin
      if (vpend_q) begin
        v_cnt_d = '0;
        v_reset = 1'b1;
        vpend_d = 1'b0;
      end else if (v_cnt_q != CNT_MAX) begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end

    // Listed after the hsync handling on purpose. A vsync edge on the same
    // strobe as an hsync edge arms the flag for the following line, even
    // though that hsync edge just consumed the old flag.
    if (vs_edge) begin
      vpend_d = 1'b1;
    end
  end

  // A line is bad if hsync arrives at the wrong count, or if the count runs
  // one past the line length with no hsync.
  assign h_bad = hs_edge ? (h_cnt_q != H_LAST) : (h_cnt_d == H_OVER);
  assign v_bad = v_reset && (v_cnt_q != V_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (i_pix_stb) begin
      case (state_q)
        ST_SEARCH: begin
          if (hs_edge && (h_cnt_q == H_LAST)) begin
            state_d = ST_HLOCK;
          end
        end
        ST_HLOCK: begin
          if (h_bad) begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
          end else if (v_reset) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (h_bad || v_bad) begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Output decode uses the post-update state. The strobe that detects a
  // violation therefore already blanks o_de.
  assign h_act   = (h_cnt_d >= H_ACT_LO) && (h_cnt_d < H_ACT_HI);
  assign v_act   = (v_cnt_d >= V_ACT_LO) && (v_cnt_d < V_ACT_HI);
  assign de_d    = (state_d == ST_LOCKED) && h_act && v_act;
  assign x_d     = de_d ? (h_cnt_d - H_ACT_LO) : '0;
  assign y_d     = de_d ? 9'(v_cnt_d - V_ACT_LO) : '0;
  assign pixel_d = de_d ? rgb_q : '0;
  assign fs_d    = de_d && (h_cnt_d == H_ACT_LO) && (v_cnt_d == V_ACT_LO);

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Previous samples start high, so a low first sample counts as an edge.
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      vpend_q   <= 1'b0;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      pixel_q   <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else if (i_pix_stb) begin
      hs_q      <= i_hs;
      vs_q      <= i_vs;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      rgb_q     <= {i_red, i_green, i_blue};
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      vpend_q   <= vpend_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pixel_q   <= pixel_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else if (i_pix_stb) begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_de          = de_q;
  assign o_pixel       = pixel_q;
  assign o_locked      = (state_q == ST_LOCKED);
  assign o_frame_start = fs_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives a shrunken VGA timing (20x12 total, 12x6 visible) through the
// decoder. The generator marks its own (line, column) for every pixel. The
// decoder output after strobe n belongs to the pixel sent at strobe n-1.
// Generator frame: hsync low for columns 0..H_SYNC-1. vsync low on the last
// line and on line 0, so the decoded row count is 0 on line 0. Visible
// pixels carry colour = x.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int H_TOTAL  = 20;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int H_ACTIVE = 12;
  localparam int V_TOTAL  = 12;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 6;
  localparam int H0       = H_SYNC + H_BP;
  localparam int V0       = V_SYNC + V_BP;
  localparam int FRAME_DE = H_ACTIVE * V_ACTIVE;

`ifdef VGA_DEC_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_pix_stb = 1'b0;
  logic       i_hs = 1'b1;
  logic       i_vs = 1'b1;
  logic [2:0] i_red = '0;
  logic [2:0] i_green = '0;
  logic [1:0] i_blue = '0;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_de;
  logic [7:0] o_pixel;
  logic       o_locked;
  logic       o_frame_start;
  logic       o_err;
  logic [7:0] o_err_cnt;

  vga_sync_decoder #(
    .H_TOTAL (H_TOTAL),  .H_SYNC (H_SYNC), .H_BP (H_BP), .H_ACTIVE (H_ACTIVE),
    .V_TOTAL (V_TOTAL),  .V_SYNC (V_SYNC), .V_BP (V_BP), .V_ACTIVE (V_ACTIVE)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pix_stb     (i_pix_stb),
    .i_hs          (i_hs),
    .i_vs          (i_vs),
    .i_red         (i_red),
    .i_green       (i_green),
    .i_blue        (i_blue),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_de          (o_de),
    .o_pixel       (o_pixel),
    .o_locked      (o_locked),
    .o_frame_start (o_frame_start),
    .o_err         (o_err),
    .o_err_cnt     (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [28:0] pack(input logic de, input int x, input int y,
                                       input logic fs, input int px);
    return {de, 10'(x), 9'(y), fs, 8'(px)};
  endfunction

  function automatic logic [38:0] all_outs();
    return {o_de, o_x, o_y, o_pixel, o_locked, o_frame_start, o_err, o_err_cnt};
  endfunction

  function automatic int exp_cnt(input int n);
    if (!CNT_EN) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  // ------------------------------------------------------- observation state
  int          prev_l = 0, prev_g = 0;
  bit          model_en = 1'b0, cap_en = 1'b0;
  int          err_pulses, de_cnt, fs_cnt, px_bad, blank_bad, fs_bad, coord_bad, hold_bad;
  logic [28:0] cap [V_TOTAL][H_TOTAL];

  task automatic clear_stats();
    err_pulses = 0; de_cnt = 0; fs_cnt = 0; px_bad = 0;
    blank_bad = 0;  fs_bad = 0; coord_bad = 0; hold_bad = 0;
  endtask

  // Called right after a strobe edge. The outputs describe (prev_l, prev_g).
  task automatic observe();
    bit exp_act;
    if (o_err) err_pulses++;
    if (o_de) de_cnt++;
    if (o_frame_start) fs_cnt++;
    if (o_de && o_pixel != o_x[7:0]) px_bad++;
    if (!o_de && (o_x != 0 || o_y != 0 || o_pixel != 0)) blank_bad++;
    if (o_frame_start && !(o_de && o_x == 0 && o_y == 0)) fs_bad++;
    if (model_en) begin
      exp_act = (prev_g >= H0) && (prev_g < H0 + H_ACTIVE) &&
                (prev_l >= V0) && (prev_l < V0 + V_ACTIVE);
      if (o_de !== exp_act) coord_bad++;
      else if (exp_act && (int'(o_x) != prev_g - H0 || int'(o_y) != prev_l - V0)) coord_bad++;
    end
    if (cap_en) cap[prev_l][prev_g] = {o_de, o_x, o_y, o_frame_start, o_pixel};
  endtask

  // --------------------------------------------------------------- generator
  task automatic send_pixel(input int l, input int g, input int gap, input bit vs_en);
    logic [7:0]  rgb;
    logic [38:0] snap;
    bit          act;
    act = (g >= H0) && (g < H0 + H_ACTIVE) && (l >= V0) && (l < V0 + V_ACTIVE);
    rgb = act ? 8'(g - H0) : 8'hA5;
    i_hs = (g >= H_SYNC);
    i_vs = vs_en ? !(l == V_TOTAL - 1 || l == 0) : 1'b1;
    {i_red, i_green, i_blue} = rgb;
    i_pix_stb = 1'b1;
    @(posedge i_clk); #1;
    i_pix_stb = 1'b0;
    observe();
    prev_l = l;
    prev_g = g;
    snap = all_outs();
    repeat (gap - 1) begin
      @(posedge i_clk); #1;
      if (all_outs() !== snap) hold_bad++;
    end
  endtask

  task automatic send_line(input int l, input int g_first, input int g_end,
                           input int gap, input bit vs_en);
    for (int g = g_first; g < g_end; g++) send_pixel(l, g, gap, vs_en);
  endtask

  task automatic send_frame(input int gap, input bit vs_en, input int odd_line,
                            input int odd_len);
    for (int l = 0; l < V_TOTAL; l++)
      send_line(l, 0, (l == odd_line) ? odd_len : H_TOTAL, gap, vs_en);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int          l;
    int          g;
    logic [28:0] exp;   // {de, x, y, frame_start, pixel}
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int l, input int g, input logic [28:0] e);
    vec_t v;
    v.l = l; v.g = g; v.exp = e;
    vecs.push_back(v);
  endtask

  // ------------------------------------------------------------------- test
  initial begin
    add_vec(4,  5,  pack(1, 0,  0, 1, 0));   // first visible pixel
    add_vec(4,  16, pack(1, 11, 0, 0, 11));  // last pixel of first row
    add_vec(4,  4,  pack(0, 0,  0, 0, 0));   // one before visible
    add_vec(4,  17, pack(0, 0,  0, 0, 0));   // one after visible
    add_vec(3,  5,  pack(0, 0,  0, 0, 0));   // line above visible area
    add_vec(9,  5,  pack(1, 0,  5, 0, 0));   // last row, first pixel
    add_vec(9,  16, pack(1, 11, 5, 0, 11));  // last visible pixel
    add_vec(10, 5,  pack(0, 0,  0, 0, 0));   // line below visible area
    add_vec(6,  10, pack(1, 5,  2, 0, 5));   // interior pixel
    add_vec(0,  0,  pack(0, 0,  0, 0, 0));   // frame origin, in sync

    clear_stats();

    // Reset state.
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_outputs", 64'(all_outs()), 64'd0);
    i_rst = 1'b0;

    // Nominal source, strobe every 4th clock.
    send_frame(4, 1'b1, -1, 0);
    check("f1_not_locked", 64'(o_locked), 64'd0);
    check("f1_no_err", 64'(err_pulses), 64'd0);

    clear_stats();
    model_en = 1'b1;
    cap_en   = 1'b1;
    send_frame(4, 1'b1, -1, 0);
    cap_en   = 1'b0;
    check("f2_locked", 64'(o_locked), 64'd1);
    check("f2_de_count", 64'(de_cnt), 64'(FRAME_DE));
    check("f2_frame_start", 64'(fs_cnt), 64'd1);

    clear_stats();
    send_frame(4, 1'b1, -1, 0);
    model_en = 1'b0;
    check("f3_de_count", 64'(de_cnt), 64'(FRAME_DE));
    check("f3_frame_start", 64'(fs_cnt), 64'd1);
    check("f3_coords", 64'(coord_bad), 64'd0);
    check("f3_pixel_eq_x", 64'(px_bad), 64'd0);
    check("f3_blank_zero", 64'(blank_bad), 64'd0);
    check("f3_fs_position", 64'(fs_bad), 64'd0);
    check("f3_hold", 64'(hold_bad), 64'd0);
    check("f3_no_err", 64'(err_pulses), 64'd0);
    check("f3_locked", 64'(o_locked), 64'd1);

    foreach (vecs[i])
      check($sformatf("vec%0d_l%0d_g%0d", i, vecs[i].l, vecs[i].g),
            64'(cap[vecs[i].l][vecs[i].g]), 64'(vecs[i].exp));

    // One line ends 10 strobes early.
    clear_stats();
    send_frame(4, 1'b1, 5, H_TOTAL - 10);
    check("early_err_pulses", 64'(err_pulses), 64'd1);
    check("early_unlocked", 64'(o_locked), 64'd0);
    send_frame(4, 1'b1, -1, 0);
    check("early_relock", 64'(o_locked), 64'd1);
    check("early_err_cnt", 64'(o_err_cnt), 64'(exp_cnt(1)));

    // vsync held high for two frames. The error appears when vsync returns
    // and the row count no longer matches the frame length.
    clear_stats();
    send_frame(4, 1'b0, -1, 0);
    send_frame(4, 1'b0, -1, 0);
    check("novs_still_locked", 64'(o_locked), 64'd1);
    check("novs_no_err_yet", 64'(err_pulses), 64'd0);
    send_frame(4, 1'b1, -1, 0);
    check("novs_err_pulses", 64'(err_pulses), 64'd1);
    check("novs_unlocked", 64'(o_locked), 64'd0);
    send_frame(4, 1'b1, -1, 0);
    check("novs_relock", 64'(o_locked), 64'd1);
    check("novs_err_cnt", 64'(o_err_cnt), 64'(exp_cnt(2)));

    // A line running past H_TOTAL with no hsync.
    clear_stats();
    send_frame(4, 1'b1, 5, H_TOTAL + 2);
    check("long_err_pulses", 64'(err_pulses), 64'd1);
    check("long_unlocked", 64'(o_locked), 64'd0);
    send_frame(4, 1'b1, -1, 0);
    check("long_relock", 64'(o_locked), 64'd1);
    check("long_err_cnt", 64'(o_err_cnt), 64'(exp_cnt(3)));

    // One-clock reset in the middle of a visible line, between strobes.
    clear_stats();
    for (int l = 0; l < 5; l++) send_line(l, 0, H_TOTAL, 4, 1'b1);
    send_line(5, 0, 10, 4, 1'b1);
    check("pre_reset_de", 64'(o_de), 64'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("mid_reset_outputs", 64'(all_outs()), 64'd0);
    send_line(5, 10, H_TOTAL, 4, 1'b1);
    for (int l = 6; l < V_TOTAL; l++) send_line(l, 0, H_TOTAL, 4, 1'b1);
    check("rst_not_locked_yet", 64'(o_locked), 64'd0);
    send_frame(4, 1'b1, -1, 0);
    check("rst_relock", 64'(o_locked), 64'd1);
    check("rst_no_err", 64'(err_pulses), 64'd0);

    // 300 forced errors: alternate a short line (error) and a good line
    // (relocks the line timing), strobing every clock.
    clear_stats();
    for (int n = 0; n < 300; n++) begin
      send_line(1, 0, H_TOTAL - 10, 1, 1'b0);
      send_line(1, 0, H_TOTAL, 1, 1'b0);
    end
    check("forced_err_pulses", 64'(err_pulses), 64'd300);
    check("forced_err_cnt", 64'(o_err_cnt), 64'(exp_cnt(300)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
